// File: rtl/toy_mem_responder.sv
// Data-memory responder for the TOY CPU load/store path: req/ack word access with
// programmable wait states, a 4096x16 array, and stdin/stdout FIFOs mapped at IO_ADDR.
module toy_mem_responder #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [11:0] IO_ADDR     = 12'hFFF,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter              INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic [15:0] rdata,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] IOSTALL = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [3:0]    WAIT_LOAD = 4'(WAIT_STATES);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [11:0] addr_q;
  logic [15:0] wdata_q;

  logic [15:0] mem [4096];

  // Stream handshakes: a word moves on a rising clk edge exactly when valid && ready
  // are both high; ready never depends combinationally on the same cycle's pop/valid.

  // ---------------- stdin FIFO ----------------
  logic [15:0]   in_buf [FIFO_DEPTH];
  logic [PW-1:0] in_wp, in_rp;
  logic [PW:0]   in_cnt, in_cnt_nxt;
  logic          in_push, in_pop, in_empty;
  logic [15:0]   in_head;

  assign in_ready = (in_cnt != CNT_FULL);
  assign in_empty = (in_cnt == '0);
  assign in_push  = in_valid && in_ready;
  assign in_head  = in_buf[in_rp];

  always_comb begin
    in_cnt_nxt = in_cnt;
    if (in_push && !in_pop)      in_cnt_nxt = in_cnt + CNT_ONE;
    else if (!in_push && in_pop) in_cnt_nxt = in_cnt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) in_wp <= in_wp + PTR_ONE;
      if (in_pop)  in_rp <= in_rp + PTR_ONE;
      in_cnt <= in_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (in_push) in_buf[in_wp] <= in_data;
  end

  // ---------------- stdout FIFO ----------------
  logic [15:0]   out_buf [FIFO_DEPTH];
  logic [PW-1:0] out_wp, out_rp;
  logic [PW:0]   out_cnt, out_cnt_nxt;
  logic          out_push, out_pop, out_full;

  assign out_valid = (out_cnt != '0);
  assign out_full  = (out_cnt == CNT_FULL);
  assign out_pop   = out_valid && out_ready;
  assign out_data  = out_buf[out_rp];

  always_comb begin
    out_cnt_nxt = out_cnt;
    if (out_push && !out_pop)      out_cnt_nxt = out_cnt + CNT_ONE;
    else if (!out_push && out_pop) out_cnt_nxt = out_cnt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (out_push) out_wp <= out_wp + PTR_ONE;
      if (out_pop)  out_rp <= out_rp + PTR_ONE;
      out_cnt <= out_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (out_push) out_buf[out_wp] <= wdata_q;
  end

  // ---------------- access FSM ----------------
  logic eval, io_hit, can_go, done, mem_we;

  // Fullness is sampled from registered counts, so a same-cycle stdout pop does not
  // let a stalled store through; it completes on the following edge.
  assign eval     = ((state == WAIT) && (cnt == '0)) || (state == IOSTALL);
  assign io_hit   = (addr_q == IO_ADDR);
  assign can_go   = !io_hit || (we_q ? !out_full : !in_empty);
  assign done     = eval && can_go;
  assign mem_we   = done && we_q && !io_hit;
  assign in_pop   = done && !we_q && io_hit;
  assign out_push = done && we_q && io_hit;

  assign ack       = (state == RESP);
  assign dbg_state = state;

  // cnt holds the extra cycles still to wait before the access is evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= WAIT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT, IOSTALL: begin
          if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= can_go ? RESP : IOSTALL;
            if (done && !we_q) rdata <= io_hit ? in_head : mem[addr_q];
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_toy_mem_responder.sv
// Bench for toy_mem_responder: table vectors, hand-written corner sequences, and a
// randomized run against an array/queue reference model. Instance 0: WAIT_STATES=1, 1: 0.
module tb_toy_mem_responder;

  localparam logic [11:0] IO = 12'hFFF;

  logic        clk;
  logic        rst_n     [2];
  logic        req       [2];
  logic        we        [2];
  logic [11:0] addr      [2];
  logic [15:0] wdata     [2];
  logic        ack       [2];
  logic [15:0] rdata     [2];
  logic        in_valid  [2];
  logic [15:0] in_data   [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [15:0] out_data  [2];
  logic        out_ready [2];
  logic [1:0]  dbg_state [2];

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q [$];      // expected stdout words of instance 0, in order
  logic [15:0] in_q  [$];      // words queued into stdin during the random run
  logic [15:0] mem_model [4096];
  logic [11:0] written [$];

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vecs [10];

  toy_mem_responder #(.WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .in_valid(in_valid[0]),
    .in_data(in_data[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_data(out_data[0]), .out_ready(out_ready[0]), .dbg_state(dbg_state[0])
  );

  toy_mem_responder #(.WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .in_valid(in_valid[1]),
    .in_data(in_data[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_data(out_data[1]), .out_ready(out_ready[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // stdout words are compared in order as they leave the FIFO
  logic [15:0] mon_exp;
  always begin
    @(negedge clk);
    #1;
    if (rst_n[0] && out_valid[0] && out_ready[0]) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stdout_unexpected got=%0h exp=none", out_data[0]);
      end else begin
        mon_exp = exp_q.pop_front();
        check("stdout_order", {16'h0, out_data[0]}, {16'h0, mon_exp});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_access(input int i, input logic w, input logic [11:0] a,
                           input logic [15:0] d, output logic [15:0] rd, output int lat);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[i] && lat < 100);
    if (!ack[i]) begin
      checks++;
      failures++;
      $display("FAIL access_timeout inst=%0d addr=%0h got=no_ack exp=ack", i, a);
    end
    rd = rdata[i];
    req[i] = 1'b0;
    @(negedge clk);
    check("ack_single_pulse", {31'h0, ack[i]}, 32'h0);
  endtask

  task automatic push_in(input int i, input logic [15:0] d);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  // ---------------- test ----------------
  logic [15:0] rd, d, exp_rd;
  logic [11:0] a;
  int lat, op;

  initial begin
    vecs[0] = '{1'b1, 12'h010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 12'h010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 12'h011, 16'h1357, 16'hBEEF};
    vecs[3] = '{1'b1, 12'h000, 16'h0F0F, 16'hBEEF};
    vecs[4] = '{1'b1, 12'hFFE, 16'hA5A5, 16'hBEEF};
    vecs[5] = '{1'b0, 12'h000, 16'h0000, 16'h0F0F};
    vecs[6] = '{1'b0, 12'hFFE, 16'h0000, 16'hA5A5};
    vecs[7] = '{1'b0, 12'h011, 16'h0000, 16'h1357};
    vecs[8] = '{1'b1, 12'h010, 16'h4242, 16'h1357};
    vecs[9] = '{1'b0, 12'h010, 16'h0000, 16'h4242};

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
      in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_ack", {31'h0, ack[i]}, 32'h0);
      check("reset_rdata", {16'h0, rdata[i]}, 32'h0);
      check("reset_out_valid", {31'h0, out_valid[i]}, 32'h0);
      check("reset_in_ready", {31'h0, in_ready[i]}, 32'h1);
      check("reset_state", {30'h0, dbg_state[i]}, 32'h0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // table vectors, WAIT_STATES=1: ack two cycles after the accept edge
    for (int v = 0; v < 10; v++) begin
      do_access(0, vecs[v].w, vecs[v].a, vecs[v].d, rd, lat);
      check("vec_latency", lat, 3);
      check("vec_rdata", {16'h0, rd}, {16'h0, vecs[v].exp_rd});
    end

    // WAIT_STATES=0: preload, then back-to-back loads with req held high
    do_access(1, 1'b1, 12'h000, 16'h1234, rd, lat);
    check("ws0_store_latency", lat, 2);
    do_access(1, 1'b1, 12'h001, 16'h5678, rd, lat);
    check("ws0_store_latency", lat, 2);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 12'h000;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check("ws0_b2b_ack", {31'h0, ack[1]}, {31'h0, (n == 2 || n == 5)});
      if (n == 2) begin
        check("ws0_b2b_rd0", {16'h0, rdata[1]}, 32'h1234);
        addr[1] = 12'h001;
      end
      if (n == 5) begin
        check("ws0_b2b_rd1", {16'h0, rdata[1]}, 32'h5678);
        req[1] = 1'b0;
      end
    end

    // IO load with empty stdin stalls until a word arrives
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = IO;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      check("iostall_no_ack", {31'h0, ack[0]}, 32'h0);
    end
    check("iostall_state", {30'h0, dbg_state[0]}, 32'h2);
    in_valid[0] = 1'b1; in_data[0] = 16'h00AA;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("ioload_pre_ack", {31'h0, ack[0]}, 32'h0);
    @(negedge clk);
    check("ioload_ack", {31'h0, ack[0]}, 32'h1);
    check("ioload_rdata", {16'h0, rdata[0]}, 32'h00AA);
    req[0] = 1'b0;
    @(negedge clk);
    check("ioload_ack_drop", {31'h0, ack[0]}, 32'h0);

    // stdout: four stores fill the FIFO, the fifth stalls until the consumer drains
    out_ready[0] = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      exp_q.push_back(16'(v));
      do_access(0, 1'b1, IO, 16'(v), rd, lat);
      check("stdout_store_latency", lat, 3);
      check("store_keeps_rdata", {16'h0, rd}, 32'h00AA);
    end
    check("stdout_full_valid", {31'h0, out_valid[0]}, 32'h1);
    check("stdout_head", {16'h0, out_data[0]}, 32'h1);
    exp_q.push_back(16'd5);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = IO; wdata[0] = 16'd5;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check("stdout_stall_no_ack", {31'h0, ack[0]}, 32'h0);
    end
    check("stdout_stall_state", {30'h0, dbg_state[0]}, 32'h2);
    out_ready[0] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ack[0] && lat < 20);
    check("stdout_5th_ack", {31'h0, ack[0]}, 32'h1);
    check("stdout_5th_latency", lat, 2);
    req[0] = 1'b0;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) @(negedge clk);
    check("stdout_drained", exp_q.size(), 0);
    @(negedge clk);
    check("stdout_empty", {31'h0, out_valid[0]}, 32'h0);

    // stdin: fill, drop a word while full, then drain across the pointer wrap
    for (int v = 1; v <= 4; v++) push_in(0, 16'hA000 + 16'(v));
    check("stdin_full", {31'h0, in_ready[0]}, 32'h0);
    in_valid[0] = 1'b1; in_data[0] = 16'h0055;
    @(negedge clk);
    in_valid[0] = 1'b0;
    check("stdin_still_full", {31'h0, in_ready[0]}, 32'h0);
    for (int v = 1; v <= 4; v++) begin
      do_access(0, 1'b0, IO, 16'h0, rd, lat);
      check("stdin_pop_latency", lat, 3);
      check("stdin_pop_data", {16'h0, rd}, {16'h0, 16'hA000 + 16'(v)});
    end
    check("stdin_not_full", {31'h0, in_ready[0]}, 32'h1);
    push_in(0, 16'hB001);
    push_in(0, 16'hB002);
    for (int v = 1; v <= 2; v++) begin
      do_access(0, 1'b0, IO, 16'h0, rd, lat);
      check("stdin_wrap_data", {16'h0, rd}, {16'h0, 16'hB000 + 16'(v)});
    end

    // randomized run against the array/queue model
    exp_rd = 16'hB002;
    for (int t = 0; t < 80; t++) begin
      op = $urandom_range(0, 3);
      if (op == 1 && written.size() == 0) op = 0;
      d = 16'($urandom);
      case (op)
        0: begin
          a = 12'h100 + 12'($urandom_range(0, 255));
          mem_model[a] = d;
          written.push_back(a);
          do_access(0, 1'b1, a, d, rd, lat);
        end
        1: begin
          a = written[$urandom_range(0, written.size() - 1)];
          exp_rd = mem_model[a];
          do_access(0, 1'b0, a, 16'h0, rd, lat);
        end
        2: begin
          exp_q.push_back(d);
          do_access(0, 1'b1, IO, d, rd, lat);
        end
        default: begin
          push_in(0, d);
          in_q.push_back(d);
          exp_rd = in_q.pop_front();
          do_access(0, 1'b0, IO, 16'h0, rd, lat);
        end
      endcase
      check("rand_latency", lat, 3);
      check("rand_rdata", {16'h0, rd}, {16'h0, exp_rd});
    end
    repeat (4) @(negedge clk);
    check("rand_stdout_drained", exp_q.size(), 0);

    // reset during the wait of a store: no ack, no commit, FIFOs emptied
    do_access(0, 1'b1, 12'h020, 16'h0001, rd, lat);
    out_ready[0] = 1'b0;
    exp_q.push_back(16'h0077);
    do_access(0, 1'b1, IO, 16'h0077, rd, lat);
    for (int v = 0; v < 4; v++) push_in(0, 16'hC000 + 16'(v));
    check("pre_reset_in_full", {31'h0, in_ready[0]}, 32'h0);
    check("pre_reset_out_valid", {31'h0, out_valid[0]}, 32'h1);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h020; wdata[0] = 16'hDEAD;
    @(negedge clk);
    check("pre_reset_wait_state", {30'h0, dbg_state[0]}, 32'h1);
    rst_n[0] = 1'b0;
    req[0] = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("reset_abort_no_ack", {31'h0, ack[0]}, 32'h0);
      check("reset_abort_out_valid", {31'h0, out_valid[0]}, 32'h0);
      check("reset_abort_in_ready", {31'h0, in_ready[0]}, 32'h1);
      check("reset_abort_state", {30'h0, dbg_state[0]}, 32'h0);
    end
    rst_n[0] = 1'b1;
    @(negedge clk);
    do_access(0, 1'b0, 12'h020, 16'h0, rd, lat);
    check("reset_no_commit_latency", lat, 3);
    check("reset_no_commit_data", {16'h0, rd}, 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
